// File: rtl/adc_sample_ctrl_if.sv
// Signal bundle between the ADC sampling controller and the surrounding logic and ADC.
// The master side is the controller; the slave side is its environment (ADC plus consumer).
interface adc_sample_ctrl_if #(
    parameter int NB_DATA = 12
) ();

    logic               i_sample_clk;
    logic               i_miso;
    logic               i_ovr_clr;
    logic               o_cs_n;
    logic               o_sclk;
    logic [NB_DATA-1:0] o_sample;
    logic               o_valid;
    logic               o_busy;
    logic               o_overrun;

    modport master (
        input  i_sample_clk,
        input  i_miso,
        input  i_ovr_clr,
        output o_cs_n,
        output o_sclk,
        output o_sample,
        output o_valid,
        output o_busy,
        output o_overrun
    );

    modport slave (
        output i_sample_clk,
        output i_miso,
        output i_ovr_clr,
        input  o_cs_n,
        input  o_sclk,
        input  o_sample,
        input  o_valid,
        input  o_busy,
        input  o_overrun
    );

endinterface

// File: rtl/adc_sample_ctrl.sv
// SPI-style ADC conversion controller: one frame per sampling-clock rising edge.
// Define ADC_SAMPLE_SIGNED_EN to present samples in two's complement instead of raw offset binary.
module adc_sample_ctrl #(
    parameter int NB_DATA  = 12,
    parameter int NB_FRAME = 15,
    parameter int SCLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    adc_sample_ctrl_if.master     bus
);

    localparam int unsigned PH_W = $clog2(2 * SCLK_DIV);
    localparam int unsigned BC_W = $clog2(NB_FRAME + 1);

    localparam logic [PH_W-1:0] PH_HALF = PH_W'(SCLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * SCLK_DIV - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(NB_FRAME - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    if (NB_FRAME < NB_DATA) begin : g_bad_frame
        $error("NB_FRAME must be >= NB_DATA");
    end
    if (SCLK_DIV < 2) begin : g_bad_div
        $error("SCLK_DIV must be >= 2");
    end
    if (NB_DATA < 2) begin : g_bad_data
        $error("NB_DATA must be >= 2");
    end

    logic [1:0]         sync_q;
    logic               sync_prev;
    logic [2:0]         prime_q;
    logic               start;

    logic [1:0]         state;
    logic [PH_W-1:0]    phase;
    logic [BC_W-1:0]    bit_cnt;
    logic [NB_DATA-1:0] shreg;
    logic [NB_DATA-1:0] sample_code;
    logic               cs_n_q;
    logic               sclk_q;
    logic [NB_DATA-1:0] sample_q;
    logic               valid_q;
    logic               overrun_q;

    // NOTE: every clocked block uses non-blocking assignments so all flops
    // update from the same pre-edge values and simulation matches hardware.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
            prime_q   <= '0;
        end else begin
            sync_q    <= {sync_q[0], bus.i_sample_clk};
            sync_prev <= sync_q[1];
            prime_q   <= {prime_q[1:0], 1'b1};
        end
    end

    // Edges are ignored until the synchronizer and history flop hold real
    // input values, so a sample clock already high at reset release is not an edge.
    assign start = prime_q[2] & sync_q[1] & ~sync_prev;

`ifdef ADC_SAMPLE_SIGNED_EN
    assign sample_code = {~shreg[NB_DATA-1], shreg[NB_DATA-2:0]};
`else
    assign sample_code = shreg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            phase    <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_SETUP;
                        cs_n_q <= 1'b0;
                        phase  <= '0;
                    end
                end
                ST_SETUP: begin
                    if (phase == PH_HALF) begin
                        state   <= ST_SHIFT;
                        phase   <= '0;
                        bit_cnt <= '0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // The edge that raises SCLK also captures MISO.
                    if (phase == PH_HALF) begin
                        sclk_q <= 1'b1;
                        shreg  <= {shreg[NB_DATA-2:0], bus.i_miso};
                    end
                    if (phase == PH_LAST) begin
                        sclk_q <= 1'b0;
                        phase  <= '0;
                        if (bit_cnt == BC_LAST) begin
                            state    <= ST_HOLD;
                            cs_n_q   <= 1'b1;
                            sample_q <= sample_code;
                            valid_q  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (phase == PH_HALF) begin
                        state <= ST_IDLE;
                        phase <= '0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // A request outside IDLE (including the HOLD exit cycle) is dropped and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (start && (state != ST_IDLE)) begin
            overrun_q <= 1'b1;
        end else if (bus.i_ovr_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign bus.o_cs_n    = cs_n_q;
    assign bus.o_sclk    = sclk_q;
    assign bus.o_sample  = sample_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_busy    = (state != ST_IDLE);
    assign bus.o_overrun = overrun_q;

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Scoreboard bench for adc_sample_ctrl: stimulus queues expected samples, a monitor pops them on o_valid.
// Also measures chip-select/busy durations, SCLK edge counts and valid spacing.
module tb_adc_sample_ctrl;

    localparam int NB_DATA  = 12;
    localparam int NB_FRAME = 15;
    localparam int SCLK_DIV = 4;

    typedef struct packed {
        logic [NB_DATA-1:0] raw;
        logic [NB_DATA-1:0] exp_u;
        logic [NB_DATA-1:0] exp_s;
    } vec_t;

    logic clk;
    logic rst;

    adc_sample_ctrl_if #(.NB_DATA(NB_DATA)) bus ();

    adc_sample_ctrl #(
        .NB_DATA  (NB_DATA),
        .NB_FRAME (NB_FRAME),
        .SCLK_DIV (SCLK_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [NB_DATA-1:0] sb[$];
    logic [NB_DATA-1:0] adc_word;
    logic               periodic_on;

    int valid_count   = 0;
    int cs_fall_count = 0;
    int sclk_rises    = 0;
    int cs_low_len    = 0;
    int busy_len      = 0;

    vec_t vecs[5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NB_DATA-1:0] exp_of(input vec_t v);
`ifdef ADC_SAMPLE_SIGNED_EN
        return v.exp_s;
`else
        return v.exp_u;
`endif
    endfunction

    // ADC model: 3 null bits then the data word MSB first, next bit presented on each SCLK fall.
    initial begin
        logic [NB_FRAME-1:0] adc_sr;
        bus.i_miso = 1'b0;
        forever begin
            @(negedge bus.o_cs_n);
            adc_sr     = {{(NB_FRAME-NB_DATA){1'b0}}, adc_word};
            bus.i_miso = adc_sr[NB_FRAME-1];
            while (bus.o_cs_n === 1'b0) begin
                @(negedge bus.o_sclk or posedge bus.o_cs_n);
                adc_sr     = adc_sr << 1;
                bus.i_miso = adc_sr[NB_FRAME-1];
            end
        end
    end

    // Monitor: scoreboard compare on o_valid plus duration/edge bookkeeping.
    initial begin
        logic prev_cs, prev_busy, prev_sclk, have_prev_valid;
        int   cs_fall_cyc, busy_rise_cyc, last_valid_cyc;
        prev_cs = 1'b1; prev_busy = 1'b0; prev_sclk = 1'b0; have_prev_valid = 1'b0;
        cs_fall_cyc = 0; busy_rise_cyc = 0; last_valid_cyc = 0;
        forever begin
            @(negedge clk);
            if (prev_cs && !bus.o_cs_n) begin
                cs_fall_cyc = cyc;
                cs_fall_count++;
            end
            if (!prev_cs && bus.o_cs_n) cs_low_len = cyc - cs_fall_cyc;
            if (!prev_busy && bus.o_busy) busy_rise_cyc = cyc;
            if (prev_busy && !bus.o_busy) busy_len = cyc - busy_rise_cyc;
            if (!prev_sclk && bus.o_sclk) sclk_rises++;
            if (!periodic_on) have_prev_valid = 1'b0;
            if (bus.o_valid) begin
                valid_count++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_valid actual=0x%0h expected=no_valid", bus.o_sample);
                end else begin
                    check("sample", 32'(bus.o_sample), 32'(sb.pop_front()));
                end
                if (periodic_on) begin
                    if (have_prev_valid) check("valid_period", 32'(cyc - last_valid_cyc), 32'd900);
                    have_prev_valid = 1'b1;
                    last_valid_cyc  = cyc;
                end
            end
            prev_cs   = bus.o_cs_n;
            prev_busy = bus.o_busy;
            prev_sclk = bus.o_sclk;
        end
    end

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int n;
        n = 0;
        while (bus.o_busy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.o_busy), 32'(lvl));
    endtask

    task automatic run_frame(input logic [NB_DATA-1:0] raw, input logic [NB_DATA-1:0] exp);
        sb.push_back(exp);
        adc_word = raw;
        bus.i_sample_clk = 1'b1;
        wait_busy(1'b1, 20, "start_timeout");
        wait_busy(1'b0, 400, "done_timeout");
        bus.i_sample_clk = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0, s0, c0;
        logic [NB_DATA-1:0] raw;

        vecs[0] = '{12'hA5C, 12'hA5C, 12'h25C};
        vecs[1] = '{12'h000, 12'h000, 12'h800};
        vecs[2] = '{12'hFFF, 12'hFFF, 12'h7FF};
        vecs[3] = '{12'h3C7, 12'h3C7, 12'hBC7};
        vecs[4] = '{12'h5B2, 12'h5B2, 12'hDB2};

        periodic_on      = 1'b0;
        adc_word         = '0;
        rst              = 1'b1;
        bus.i_sample_clk = 1'b0;
        bus.i_ovr_clr    = 1'b0;
        repeat (5) @(negedge clk);

        check("rst_cs_n",    32'(bus.o_cs_n),    32'd1);
        check("rst_sclk",    32'(bus.o_sclk),    32'd0);
        check("rst_sample",  32'(bus.o_sample),  32'd0);
        check("rst_valid",   32'(bus.o_valid),   32'd0);
        check("rst_busy",    32'(bus.o_busy),    32'd0);
        check("rst_overrun", 32'(bus.o_overrun), 32'd0);

        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Single frame with timing and edge counts.
        v0 = valid_count;
        s0 = sclk_rises;
        run_frame(vecs[0].raw, exp_of(vecs[0]));
        check("cs_low_len",   32'(cs_low_len),        32'd124);
        check("busy_len",     32'(busy_len),          32'd128);
        check("sclk_rises",   32'(sclk_rises - s0),   32'd15);
        check("valid_pulses", 32'(valid_count - v0),  32'd1);
        check("no_overrun",   32'(bus.o_overrun),     32'd0);

        // Endpoints, then the output must hold between conversions.
        run_frame(vecs[1].raw, exp_of(vecs[1]));
        run_frame(vecs[2].raw, exp_of(vecs[2]));
        repeat (50) @(negedge clk);
        check("sample_hold", 32'(bus.o_sample), 32'(exp_of(vecs[2])));

        // Overrun: second request 50 cycles after the first.
        v0 = valid_count;
        sb.push_back(exp_of(vecs[3]));
        adc_word = vecs[3].raw;
        bus.i_sample_clk = 1'b1;
        repeat (25) @(negedge clk);
        bus.i_sample_clk = 1'b0;
        repeat (25) @(negedge clk);
        bus.i_sample_clk = 1'b1;
        wait_busy(1'b0, 400, "ovr_done_timeout");
        bus.i_sample_clk = 1'b0;
        repeat (10) @(negedge clk);
        check("ovr_set",     32'(bus.o_overrun),     32'd1);
        check("ovr_valids",  32'(valid_count - v0),  32'd1);
        check("ovr_sample",  32'(bus.o_sample),      32'(exp_of(vecs[3])));
        bus.i_ovr_clr = 1'b1;
        @(negedge clk);
        bus.i_ovr_clr = 1'b0;
        @(negedge clk);
        check("ovr_cleared", 32'(bus.o_overrun), 32'd0);

        // Reset 60 cycles into a conversion; sample clock stays high across release.
        v0 = valid_count;
        adc_word = 12'h999;
        bus.i_sample_clk = 1'b1;
        wait_busy(1'b1, 20, "abort_start_timeout");
        repeat (60) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_cs_n",   32'(bus.o_cs_n),   32'd1);
        check("abort_sclk",   32'(bus.o_sclk),   32'd0);
        check("abort_sample", 32'(bus.o_sample), 32'd0);
        check("abort_busy",   32'(bus.o_busy),   32'd0);
        repeat (5) @(negedge clk);
        c0 = cs_fall_count;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("high_at_release_no_start", 32'(cs_fall_count - c0), 32'd0);
        check("abort_no_valid",           32'(valid_count - v0),   32'd0);
        bus.i_sample_clk = 1'b0;
        repeat (10) @(negedge clk);
        run_frame(vecs[4].raw, exp_of(vecs[4]));
        check("post_abort_valids", 32'(valid_count - v0), 32'd1);

        // Periodic sampling clock: 900-cycle period, 50% duty, 10 periods.
        v0 = valid_count;
        periodic_on = 1'b1;
        for (int i = 0; i < 10; i++) begin
            raw = NB_DATA'(12'h123 + 12'h0F1 * i);
`ifdef ADC_SAMPLE_SIGNED_EN
            sb.push_back(raw ^ 12'h800);
`else
            sb.push_back(raw);
`endif
            adc_word = raw;
            bus.i_sample_clk = 1'b1;
            repeat (450) @(negedge clk);
            bus.i_sample_clk = 1'b0;
            repeat (450) @(negedge clk);
        end
        periodic_on = 1'b0;
        check("periodic_valids",  32'(valid_count - v0), 32'd10);
        check("periodic_overrun", 32'(bus.o_overrun),    32'd0);
        check("sb_drained",       32'(sb.size()),        32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_sample_ctrl.md
ADC_SAMPLE_CTRL -- requirements
Module: adc_sample_ctrl

Interface
REQ-001 Parameter NB_DATA, default 12, ADC sample width in bits.
REQ-002 Parameter NB_FRAME, default 15, SCLK periods per conversion frame; SHALL be greater than or equal to NB_DATA.
REQ-003 Parameter SCLK_DIV, default 4, clk cycles per SCLK half-period; SHALL be at least 2.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 i_sample_clk  input  1  low-speed sampling clock from the counter-based clock divider; each rising edge requests one conversion.
REQ-007 i_miso  input  1  serial data from the ADC, MSB first.
REQ-008 i_ovr_clr  input  1  synchronous clear of o_overrun.
REQ-009 o_cs_n  output  1  ADC chip select, active-low.
REQ-010 o_sclk  output  1  ADC serial clock.
REQ-011 o_sample  output  NB_DATA  last completed sample.
REQ-012 o_valid  output  1  one-cycle pulse when o_sample updates.
REQ-013 o_busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 o_overrun  output  1  sticky flag set by a request that arrives while busy.

Function
REQ-015 i_sample_clk SHALL pass through a 2-flop synchronizer followed by a rising-edge detector.
REQ-016 The edge detector SHALL produce a one-cycle start pulse.
REQ-017 The FSM SHALL have four states: IDLE, SETUP, SHIFT, HOLD.
REQ-018 In IDLE, a start pulse SHALL cause a transition to SETUP, and o_cs_n SHALL fall on that same clk edge.
REQ-019 SETUP SHALL last SCLK_DIV cycles with o_cs_n=0 and o_sclk=0, then transition to SHIFT.
REQ-020 SHIFT SHALL generate NB_FRAME SCLK periods, each consisting of SCLK_DIV cycles low followed by SCLK_DIV cycles high.
REQ-021 i_miso SHALL be shifted into the shift register on the clk edge that drives o_sclk from 0 to 1.
REQ-022 After the last high half-period of SHIFT, o_sclk SHALL return to 0 and o_cs_n SHALL return to 1, and the FSM SHALL enter HOLD.
REQ-023 On HOLD entry, o_sample SHALL load the low NB_DATA shift-register bits (the last NB_DATA bits received), and o_valid SHALL pulse for exactly 1 cycle.
REQ-024 HOLD SHALL last SCLK_DIV cycles with o_cs_n=1, then return to IDLE.
REQ-025 o_cs_n low time SHALL be SCLK_DIV*(1+2*NB_FRAME) cycles; with defaults this is 124 cycles.
REQ-026 The total busy time SHALL be SCLK_DIV*(2+2*NB_FRAME) cycles; with defaults this is 128 cycles.
REQ-027 A start pulse in SETUP, SHIFT, or HOLD SHALL be ignored (no restart, no queuing) and SHALL set o_overrun on the next edge.
REQ-028 i_ovr_clr clears o_overrun; if i_ovr_clr and a new overrun occur in the same cycle, set SHALL win.
REQ-029 A start pulse arriving in the same cycle that HOLD exits to IDLE SHALL be treated as an overrun.
REQ-030 o_sample SHALL hold its value between conversions.
REQ-031 The phase counter SHALL be ceil(log2(2*SCLK_DIV)) bits wide and the bit counter SHALL be ceil(log2(NB_FRAME+1)) bits wide; neither counter SHALL wrap mid-frame.

Reset
REQ-032 While rst=1, outputs SHALL be: o_cs_n=1, o_sclk=0, o_sample=0, o_valid=0, o_busy=0, o_overrun=0.
REQ-033 While rst=1, the FSM SHALL be in IDLE, and the counters, shift register, and synchronizer flops SHALL be 0.
REQ-034 A reset asserted mid-conversion SHALL abort the conversion immediately, without producing an o_valid pulse.
REQ-035 After reset release, the first rising edge of i_sample_clk SHALL start a normal conversion.
REQ-036 If i_sample_clk is already high at reset release, no conversion SHALL start until it goes low and then high again.

Configuration
REQ-037 Macro ADC_SAMPLE_SIGNED_EN selects the output encoding.
REQ-038 When ADC_SAMPLE_SIGNED_EN is defined, o_sample SHALL be two's complement: raw − 2^(NB_DATA−1), computed by inverting the MSB of the raw value, registered with no added latency.
REQ-039 When ADC_SAMPLE_SIGNED_EN is not defined, o_sample SHALL be the raw unsigned ADC code.

Verification
REQ-040 Single frame: the ADC model drives 3 null bits, then 0xA5C. Required response: o_sample=0xA5C (0x25C with ADC_SAMPLE_SIGNED_EN), one o_valid pulse, and exactly 15 SCLK rising edges.
REQ-041 Timing: on a single frame, measure the interval from o_cs_n falling to o_cs_n rising (124 cycles) and o_busy high time (128 cycles).
REQ-042 Endpoints: drive data 0x000 and 0xFFF. Required response: 0x000/0xFFF unsigned, or 0x800/0x7FF with ADC_SAMPLE_SIGNED_EN.
REQ-043 Overrun: a second i_sample_clk rising edge 50 cycles after the first. Required response: o_overrun=1, only one o_valid pulse, first sample intact; o_overrun clears after a 1-cycle i_ovr_clr pulse.
REQ-044 Reset mid-SHIFT (cycle 60): o_cs_n=1 and o_sclk=0 during reset, no o_valid pulse, o_sample=0; the next i_sample_clk edge completes a normal frame.
REQ-045 Periodic: drive i_sample_clk at a period of 900 clk cycles (50% duty cycle) for 10 periods. Required response: 10 o_valid pulses spaced 900 cycles apart and o_overrun=0.
